// File: rtl/fsm_job_responder.sv
// Target-side job responder for the start/done/fault supervisory controller.
// Times a programmable-length job while busy_i is high, filters the sensor error, and holds done/fault.
module fsm_job_responder #(
  parameter int CNT_W = 16,
  parameter int FLT_N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             busy_i,
  input  logic [CNT_W-1:0] job_len_i,
  input  logic             sensor_err_i,
  input  logic             fault_clr_i,
  output logic             done_o,
  output logic             fault_o,
  output logic             abort_o,
  output logic [CNT_W-1:0] elapsed_o,
  output logic [1:0]       rstate_o
);

  // Handshake: busy_i is a level "go" from the controller. done_o/fault_o are levels held until
  // the controller leaves RUN (busy_i low) or the operator clears a fault with the sensor quiet.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  localparam int FLT_W = 4;
  localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FLT_N);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [CNT_W-1:0] elapsed_nxt;
  logic [FLT_W-1:0] flt_cnt, flt_cnt_nxt;
  logic             flt_hit;
  logic             abort_nxt;

  assign flt_hit  = (flt_cnt == FLT_MAX);
  assign rstate_o = state;

  always_comb begin
    state_nxt   = state;
    rem_nxt     = rem;
    elapsed_nxt = elapsed_o;
    abort_nxt   = 1'b0;
    flt_cnt_nxt = '0;

    if (sensor_err_i) begin
      flt_cnt_nxt = flt_hit ? flt_cnt : flt_cnt + FLT_W'(1);
    end

    // Priority inside each state: fault, then abort, then completion.
    case (state)
      S_IDLE: begin
        if (flt_hit) begin
          state_nxt = S_FAULT;
        end else if (busy_i) begin
          rem_nxt     = (job_len_i == '0) ? ONE : job_len_i;
          elapsed_nxt = '0;
          state_nxt   = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (flt_hit) begin
          state_nxt = S_FAULT;
        end else if (!busy_i) begin
          abort_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else if (rem == ONE) begin
          state_nxt = S_DONE;
        end else begin
          rem_nxt     = rem - ONE;
          elapsed_nxt = (elapsed_o == '1) ? elapsed_o : elapsed_o + ONE;
        end
      end
      S_DONE: begin
        if (flt_hit) begin
          state_nxt = S_FAULT;
        end else if (!busy_i) begin
          state_nxt = S_IDLE;
        end
      end
      S_FAULT: begin
        if (fault_clr_i && (flt_cnt == '0)) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rem       <= '0;
      elapsed_o <= '0;
      flt_cnt   <= '0;
      done_o    <= 1'b0;
      fault_o   <= 1'b0;
      abort_o   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rem       <= rem_nxt;
      elapsed_o <= elapsed_nxt;
      flt_cnt   <= flt_cnt_nxt;
      // Flags follow the next state so they are registered yet aligned with rstate_o.
      done_o    <= (state_nxt == S_DONE);
      fault_o   <= (state_nxt == S_FAULT);
      abort_o   <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_fsm_job_responder.sv
// Directed bench for fsm_job_responder: job timing, filter, abort, collisions, reset, closed loop.
module tb_fsm_job_responder;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             busy_drv;
  logic             busy_i;
  logic [CNT_W-1:0] job_len_i;
  logic             sensor_err_i;
  logic             fault_clr_i;
  logic             done_o;
  logic             fault_o;
  logic             abort_o;
  logic [CNT_W-1:0] elapsed_o;
  logic [1:0]       rstate_o;

  int checks   = 0;
  int failures = 0;

  // Behavioural supervisory controller: 0 IDLE, 1 RUN, 2 ERR.
  logic       loop_mode;
  logic       start;
  logic [1:0] ctrl_st;
  int         ctrl_done_cnt;
  int         ctrl_err_cnt;
  int         overlap_cnt;

  assign busy_i = loop_mode ? (ctrl_st == 2'd1) : busy_drv;

  fsm_job_responder #(.CNT_W(CNT_W), .FLT_N(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .busy_i       (busy_i),
    .job_len_i    (job_len_i),
    .sensor_err_i (sensor_err_i),
    .fault_clr_i  (fault_clr_i),
    .done_o       (done_o),
    .fault_o      (fault_o),
    .abort_o      (abort_o),
    .elapsed_o    (elapsed_o),
    .rstate_o     (rstate_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_st <= 2'd0;
    end else begin
      case (ctrl_st)
        2'd0: if (start) ctrl_st <= 2'd1;
        2'd1: begin
          if (fault_o) begin
            ctrl_st <= 2'd2;
            ctrl_err_cnt <= ctrl_err_cnt + 1;
          end else if (done_o) begin
            ctrl_st <= 2'd0;
            ctrl_done_cnt <= ctrl_done_cnt + 1;
          end
        end
        2'd2: if (fault_clr_i) ctrl_st <= 2'd0;
        default: ctrl_st <= 2'd0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (loop_mode && done_o && fault_o) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({done_o, fault_o, abort_o} !== 3'b000 || rstate_o !== 2'd0 || elapsed_o !== '0) begin
      failures++;
      $display("FAIL reset_vals got d/f/a=%b%b%b st=%0d el=%0d exp 000 0 0",
               done_o, fault_o, abort_o, rstate_o, elapsed_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    int bad = 0;
    job_len_i = 16'd4;
    busy_drv  = 1'b1;
    tick();
    checks++;
    if (rstate_o !== 2'd1) begin
      failures++;
      $display("FAIL normal_start got st=%0d exp 1", rstate_o);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (done_o !== 1'b0 || rstate_o !== 2'd1 || fault_o || abort_o) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL normal_active got bad_cycles=%0d exp 0", bad);
    end
    tick();
    checks++;
    if (done_o !== 1'b1 || rstate_o !== 2'd2 || elapsed_o !== 16'd3) begin
      failures++;
      $display("FAIL normal_done got d=%b st=%0d el=%0d exp 1 2 3", done_o, rstate_o, elapsed_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b1 || fault_o !== 1'b0) begin
      failures++;
      $display("FAIL normal_hold got d=%b f=%b exp 1 0", done_o, fault_o);
    end
    busy_drv = 1'b0;
    tick();
    checks++;
    if (done_o !== 1'b0 || rstate_o !== 2'd0 || elapsed_o !== 16'd3 || abort_o !== 1'b0) begin
      failures++;
      $display("FAIL normal_release got d=%b st=%0d el=%0d a=%b exp 0 0 3 0",
               done_o, rstate_o, elapsed_o, abort_o);
    end
  endtask

  task automatic test_zero_len();
    job_len_i = 16'd0;
    busy_drv  = 1'b1;
    tick();
    tick();
    checks++;
    if (done_o !== 1'b1 || elapsed_o !== 16'd0) begin
      failures++;
      $display("FAIL zero_len got d=%b el=%0d exp 1 0", done_o, elapsed_o);
    end
    busy_drv = 1'b0;
    tick();
  endtask

  task automatic test_filter();
    int bad = 0;
    // Two-cycle glitch: filtered out, job runs to completion.
    job_len_i = 16'd20;
    busy_drv  = 1'b1;
    tick();
    for (int i = 1; i <= 20; i++) begin
      sensor_err_i = (i == 3 || i == 4);
      tick();
      if (fault_o !== 1'b0) bad++;
      if (i < 20 && done_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || done_o !== 1'b1 || elapsed_o !== 16'd19) begin
      failures++;
      $display("FAIL filter_glitch got bad=%0d d=%b el=%0d exp 0 1 19", bad, done_o, elapsed_o);
    end
    busy_drv = 1'b0;
    tick();
    // Three-cycle error: fault declared, busy ignored while faulted.
    busy_drv = 1'b1;
    tick();
    sensor_err_i = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (fault_o !== 1'b0 || rstate_o !== 2'd1) begin
      failures++;
      $display("FAIL filter_pre got f=%b st=%0d exp 0 1", fault_o, rstate_o);
    end
    tick();
    checks++;
    if (fault_o !== 1'b1 || rstate_o !== 2'd3 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL filter_fault got f=%b st=%0d d=%b exp 1 3 0", fault_o, rstate_o, done_o);
    end
    fault_clr_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rstate_o !== 2'd3 || fault_o !== 1'b1 || done_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL filter_clr_blocked got bad_cycles=%0d exp 0", bad);
    end
    sensor_err_i = 1'b0;
    busy_drv     = 1'b0;
    tick();
    checks++;
    if (rstate_o !== 2'd3) begin
      failures++;
      $display("FAIL filter_clr_wait got st=%0d exp 3", rstate_o);
    end
    tick();
    checks++;
    if (rstate_o !== 2'd0 || fault_o !== 1'b0) begin
      failures++;
      $display("FAIL filter_clr got st=%0d f=%b exp 0 0", rstate_o, fault_o);
    end
    fault_clr_i = 1'b0;
  endtask

  task automatic test_abort();
    job_len_i = 16'd10;
    busy_drv  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    busy_drv = 1'b0;
    tick();
    checks++;
    if (abort_o !== 1'b1 || rstate_o !== 2'd0 || done_o !== 1'b0 || elapsed_o !== 16'd4) begin
      failures++;
      $display("FAIL abort_pulse got a=%b st=%0d d=%b el=%0d exp 1 0 0 4",
               abort_o, rstate_o, done_o, elapsed_o);
    end
    tick();
    checks++;
    if (abort_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_single got a=%b exp 0", abort_o);
    end
  endtask

  task automatic test_collision();
    job_len_i = 16'd4;
    busy_drv  = 1'b1;
    tick();
    sensor_err_i = 1'b1;
    tick();
    tick();
    tick();
    sensor_err_i = 1'b0;
    tick();
    checks++;
    if (fault_o !== 1'b1 || done_o !== 1'b0 || rstate_o !== 2'd3) begin
      failures++;
      $display("FAIL collision got f=%b d=%b st=%0d exp 1 0 3", fault_o, done_o, rstate_o);
    end
    fault_clr_i = 1'b1;
    busy_drv    = 1'b0;
    tick();
    checks++;
    if (rstate_o !== 2'd0 || fault_o !== 1'b0) begin
      failures++;
      $display("FAIL collision_clr got st=%0d f=%b exp 0 0", rstate_o, fault_o);
    end
    fault_clr_i = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    job_len_i = 16'd10;
    busy_drv  = 1'b1;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({done_o, fault_o, abort_o} !== 3'b000 || rstate_o !== 2'd0 || elapsed_o !== '0) begin
      failures++;
      $display("FAIL reset_mid got d/f/a=%b%b%b st=%0d el=%0d exp 000 0 0",
               done_o, fault_o, abort_o, rstate_o, elapsed_o);
    end
    busy_drv = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (done_o !== 1'b0 || fault_o !== 1'b0 || rstate_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_after got d=%b f=%b st=%0d exp 0 0 0", done_o, fault_o, rstate_o);
    end
  endtask

  task automatic run_job(input logic [CNT_W-1:0] len, input logic with_fault);
    int n;
    job_len_i = len;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (with_fault) begin
      sensor_err_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      sensor_err_i = 1'b0;
      n = 0;
      while (ctrl_st != 2'd2 && n < 40) begin
        tick();
        n++;
      end
      checks++;
      if (ctrl_st !== 2'd2 || rstate_o !== 2'd3) begin
        failures++;
        $display("FAIL loop_fault got ctrl=%0d st=%0d exp 2 3", ctrl_st, rstate_o);
      end
      fault_clr_i = 1'b1;
    end
    n = 0;
    while (!(ctrl_st == 2'd0 && rstate_o == 2'd0) && n < 60) begin
      tick();
      n++;
    end
    fault_clr_i = 1'b0;
    checks++;
    if (ctrl_st !== 2'd0 || rstate_o !== 2'd0) begin
      failures++;
      $display("FAIL loop_settle got ctrl=%0d st=%0d exp 0 0", ctrl_st, rstate_o);
    end
    tick();
  endtask

  task automatic test_closed_loop();
    ctrl_done_cnt = 0;
    ctrl_err_cnt  = 0;
    overlap_cnt   = 0;
    loop_mode     = 1'b1;
    tick();
    run_job(16'd3, 1'b0);
    run_job(16'd5, 1'b1);
    run_job(16'd2, 1'b0);
    checks++;
    if (ctrl_done_cnt != 2 || ctrl_err_cnt != 1 || overlap_cnt != 0) begin
      failures++;
      $display("FAIL loop_counts got done=%0d err=%0d overlap=%0d exp 2 1 0",
               ctrl_done_cnt, ctrl_err_cnt, overlap_cnt);
    end
    loop_mode = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    busy_drv     = 1'b0;
    job_len_i    = '0;
    sensor_err_i = 1'b0;
    fault_clr_i  = 1'b0;
    loop_mode    = 1'b0;
    start        = 1'b0;
    ctrl_done_cnt = 0;
    ctrl_err_cnt  = 0;
    overlap_cnt   = 0;
    test_reset();
    tick();
    test_normal();
    test_zero_len();
    test_filter();
    test_abort();
    test_collision();
    test_reset_mid_job();
    test_closed_loop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
